// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side bundle for branch_resolve_ctrl: IF push, EX resolve, flush/redirect,
// predictor update strobe and statistics counters.
interface branch_resolve_ctrl_if;
  logic        if_valid;
  logic        if_is_branch;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic [15:0] if_pred_target;
  logic        if_ready;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic [15:0] mispred_cnt;
  logic [15:0] branch_cnt;

  modport master (
    output if_valid, if_is_branch, if_pc, if_pred_taken, if_pred_target,
    output ex_valid, ex_pc, ex_taken, ex_target,
    input  if_ready, flush, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken, mispred_cnt, branch_cnt
  );

  modport slave (
    input  if_valid, if_is_branch, if_pc, if_pred_taken, if_pred_target,
    input  ex_valid, ex_pc, ex_taken, ex_target,
    output if_ready, flush, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken, mispred_cnt, branch_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order branch tracker: compares IF predictions with EX resolution, drives flush/redirect
// and predictor updates. Define BRC_STATS_EN to enable the saturating branch/mispredict counters.
module branch_resolve_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  branch_resolve_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_nxt;

  logic [15:0]   r_trk_pc   [DEPTH];
  logic          r_trk_ptak [DEPTH];
  logic [15:0]   r_trk_ptgt [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_flush, r_redirect_valid, r_upd_valid, r_upd_taken;
  logic [15:0]   r_redirect_pc, r_upd_pc, r_upd_target;

  logic          w_ready, w_push, w_resolve, w_hit, w_pop, w_mispred;
  logic          w_pred_taken;
  logic [15:0]   w_pred_target, w_corr_pc;

  always_comb begin
    w_ready       = (r_state == ST_RUN) && (r_count < CW'(DEPTH));
    w_push        = bus.if_valid & bus.if_is_branch & w_ready;
    w_resolve     = bus.ex_valid & (r_state == ST_RUN);
    w_hit         = (r_count != '0) && (r_trk_pc[r_rd_ptr] == bus.ex_pc);
    w_pred_taken  = w_hit & r_trk_ptak[r_rd_ptr];
    w_pred_target = w_hit ? r_trk_ptgt[r_rd_ptr] : '0;
    w_mispred     = w_resolve & ((w_pred_taken != bus.ex_taken) |
                                 (bus.ex_taken & (w_pred_target != bus.ex_target)));
    w_pop         = w_resolve & w_hit;
    w_corr_pc     = bus.ex_taken ? bus.ex_target : bus.ex_pc + 16'd1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mispred) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FW'(FLUSH_CYC);
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt <= FW'(1)) begin
          w_state_nxt     = ST_RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FW'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // A mispredict discards every tracked entry, so a same-cycle push is dropped too.
  always_ff @(posedge clk) begin
    if (rst || w_mispred) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_mispred) begin
      r_trk_pc[r_wr_ptr]   <= bus.if_pc;
      r_trk_ptak[r_wr_ptr] <= bus.if_pred_taken;
      r_trk_ptgt[r_wr_ptr] <= bus.if_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_target     <= '0;
      r_upd_taken      <= 1'b0;
    end else begin
      r_flush          <= (w_state_nxt == ST_FLUSH);
      r_redirect_valid <= w_mispred;
      r_upd_valid      <= w_resolve;
      if (w_mispred) r_redirect_pc <= w_corr_pc;
      if (w_resolve) begin
        r_upd_pc     <= bus.ex_pc;
        r_upd_target <= bus.ex_target;
        r_upd_taken  <= bus.ex_taken;
      end
    end
  end

`ifdef BRC_STATS_EN
  logic [15:0] r_branch_cnt, r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (r_upd_valid && (r_branch_cnt != '1))       r_branch_cnt  <= r_branch_cnt + 16'd1;
      if (r_redirect_valid && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;
`else
  assign bus.branch_cnt  = '0;
  assign bus.mispred_cnt = '0;
`endif

  assign bus.if_ready       = w_ready;
  assign bus.flush          = r_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_pc         = r_upd_pc;
  assign bus.upd_target     = r_upd_target;
  assign bus.upd_taken      = r_upd_taken;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed pushes/resolves queue their expected
// update/redirect; a negedge monitor pops and compares, and tracks the flush window.
module tb_branch_resolve_ctrl;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FLUSH_CYC = 2;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        tk;
    logic        mis;
    logic [15:0] rpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  logic mon_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_left = 0;
  int   exp_br = 0;
  int   exp_mp = 0;
  exp_t exp_q[$];

  branch_resolve_ctrl_if bus();

  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_q  <= rst;
    mon_en <= 1'b1;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        exp_left = 0;
        chk("rst_flush", bus.flush, 16'h0);
        chk("rst_upd_valid", bus.upd_valid, 16'h0);
        chk("rst_redirect_valid", bus.redirect_valid, 16'h0);
      end else begin
        if (bus.upd_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_upd", 16'h1, 16'h0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("upd_pc", bus.upd_pc, e.pc);
            chk("upd_target", bus.upd_target, e.tgt);
            chk("upd_taken", bus.upd_taken, e.tk);
            chk("redirect_valid", bus.redirect_valid, e.mis);
            if (e.mis) begin
              chk("redirect_pc", bus.redirect_pc, e.rpc);
              exp_left = FLUSH_CYC;
            end
          end
        end else begin
          chk("idle_redirect_valid", bus.redirect_valid, 16'h0);
        end
        chk("flush", bus.flush, (exp_left != 0) ? 16'h1 : 16'h0);
        if (exp_left > 0) exp_left--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of optional push and optional resolve; a mispredict waits out the flush.
  task automatic step(input logic dp, input logic [15:0] ppc, input logic pt, input logic [15:0] ptgt,
                      input logic dr, input logic [15:0] epc, input logic et, input logic [15:0] etgt,
                      input logic mis, input logic [15:0] rpc);
    exp_t e;
    bus.if_valid       = dp;
    bus.if_is_branch   = dp;
    bus.if_pc          = ppc;
    bus.if_pred_taken  = pt;
    bus.if_pred_target = ptgt;
    bus.ex_valid       = dr;
    bus.ex_pc          = epc;
    bus.ex_taken       = et;
    bus.ex_target      = etgt;
    if (dr) begin
      e.pc = epc; e.tgt = etgt; e.tk = et; e.mis = mis; e.rpc = rpc;
      exp_q.push_back(e);
      exp_br++;
      if (mis) exp_mp++;
    end
    tick();
    bus.if_valid = 1'b0;
    bus.if_is_branch = 1'b0;
    bus.ex_valid = 1'b0;
    if (dr && mis) begin
      for (int unsigned i = 0; i < FLUSH_CYC; i++) begin
        chk("flush_if_ready", bus.if_ready, 16'h0);
        tick();
      end
      chk("post_flush_if_ready", bus.if_ready, 16'h1);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic pt, input logic [15:0] ptgt);
    step(1'b1, pc, pt, ptgt, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic resolve(input logic [15:0] pc, input logic et, input logic [15:0] etgt,
                         input logic mis, input logic [15:0] rpc);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, pc, et, etgt, mis, rpc);
  endtask

  task automatic chk_stats(input string nm, input int br, input int mp);
`ifdef BRC_STATS_EN
    chk({nm, "_branch_cnt"}, bus.branch_cnt, 16'(br));
    chk({nm, "_mispred_cnt"}, bus.mispred_cnt, 16'(mp));
`else
    chk({nm, "_branch_cnt"}, bus.branch_cnt, 16'h0);
    chk({nm, "_mispred_cnt"}, bus.mispred_cnt, 16'h0);
`endif
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_valid = 1'b0; bus.if_is_branch = 1'b0; bus.if_pc = '0;
    bus.if_pred_taken = 1'b0; bus.if_pred_target = '0;
    bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_taken = 1'b0; bus.ex_target = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_flush", bus.flush, 16'h0);
    chk("reset_redirect_pc", bus.redirect_pc, 16'h0);
    chk("reset_upd_pc", bus.upd_pc, 16'h0);
    chk("reset_upd_target", bus.upd_target, 16'h0);
    chk("reset_upd_taken", bus.upd_taken, 16'h0);
    chk("reset_if_ready", bus.if_ready, 16'h1);
    chk_stats("reset", 0, 0);
    rst = 1'b0;

    // Three correctly predicted taken branches
    for (int k = 0; k < 3; k++) begin
      push(16'h0010, 1'b1, 16'h0040);
      resolve(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0);
    end
    chk("correct_if_ready", bus.if_ready, 16'h1);

    // Direction mispredict; the younger 0x0022 entry must be discarded
    push(16'h0020, 1'b0, 16'h0021);
    push(16'h0022, 1'b1, 16'h0050);
    resolve(16'h0020, 1'b1, 16'h0080, 1'b1, 16'h0080);
    resolve(16'h0022, 1'b1, 16'h0050, 1'b1, 16'h0050);

    // Fall-through wraps to 0x0000
    push(16'hFFFF, 1'b1, 16'h1234);
    resolve(16'hFFFF, 1'b0, 16'h7777, 1'b1, 16'h0000);

    // Full tracker; push with same-cycle correct pop is refused, next push accepted
    push(16'h0100, 1'b0, 16'h0);
    push(16'h0101, 1'b0, 16'h0);
    push(16'h0102, 1'b0, 16'h0);
    push(16'h0103, 1'b0, 16'h0);
    chk("full_if_ready", bus.if_ready, 16'h0);
    step(1'b1, 16'h0104, 1'b1, 16'h0200, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("after_pop_if_ready", bus.if_ready, 16'h1);
    push(16'h0104, 1'b1, 16'h0200);
    chk("refull_if_ready", bus.if_ready, 16'h0);
    resolve(16'h0101, 1'b0, 16'h0, 1'b0, 16'h0);
    resolve(16'h0102, 1'b0, 16'h0, 1'b0, 16'h0);
    resolve(16'h0103, 1'b0, 16'h0, 1'b0, 16'h0);
    resolve(16'h0104, 1'b1, 16'h0200, 1'b0, 16'h0);
    resolve(16'h0104, 1'b1, 16'h0200, 1'b1, 16'h0200);

    // Resolves against an empty tracker use the not-taken default
    resolve(16'h0030, 1'b1, 16'h0005, 1'b1, 16'h0005);
    resolve(16'h0030, 1'b0, 16'h0005, 1'b0, 16'h0);

    // Push alongside a mispredicting resolve is dropped
    step(1'b1, 16'h0300, 1'b1, 16'h0400, 1'b1, 16'h0400, 1'b1, 16'h0444, 1'b1, 16'h0444);
    resolve(16'h0300, 1'b1, 16'h0400, 1'b1, 16'h0400);

    // Correct resolve with same-cycle push keeps the new entry
    push(16'h0500, 1'b1, 16'h0600);
    step(1'b1, 16'h0501, 1'b1, 16'h0700, 1'b1, 16'h0500, 1'b1, 16'h0600, 1'b0, 16'h0);
    resolve(16'h0501, 1'b1, 16'h0700, 1'b0, 16'h0);

    tick();
    tick();
    chk_stats("stats", exp_br, exp_mp);

    // Reset in the first flush cycle
    bus.ex_valid = 1'b1; bus.ex_pc = 16'h0900; bus.ex_taken = 1'b1; bus.ex_target = 16'h0A00;
    begin
      exp_t e;
      e.pc = 16'h0900; e.tgt = 16'h0A00; e.tk = 1'b1; e.mis = 1'b1; e.rpc = 16'h0A00;
      exp_q.push_back(e);
    end
    tick();
    bus.ex_valid = 1'b0;
    chk("midflush_flush", bus.flush, 16'h1);
    rst = 1'b1;
    tick();
    chk("rst_midflush_flush", bus.flush, 16'h0);
    chk("rst_midflush_if_ready", bus.if_ready, 16'h1);
    chk_stats("rst_midflush", 0, 0);
    rst = 1'b0;
    resolve(16'h0040, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    tick();
    chk("scoreboard_pending", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
